esfa_run_controller: RTL and testbench

Run-control responder for the ESFA top level. It implements the device side of the `doRun` / `isRunning` / `wasSuccessful` benchmark handshake that a bench or host drives. On a run request it sequences `NUM_OPS` operations through a worker with a start/done handshake, times out stuck operations, and measures total run cycles. It reports pass/fail and holds the result until the requester drops `doRun`.

---
 rtl/esfa_run_controller.sv | 152 +++++++++++++++
 tb/tb_esfa_run_controller.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/esfa_run_controller.sv
// Device side of the doRun / isRunning / wasSuccessful run handshake: sequences
// NUM_OPS worker operations, times out stuck ones and counts run cycles.
module esfa_run_controller #(
  parameter int unsigned NUM_OPS = 16,
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned CYCLE_W = 32,
  localparam int unsigned IDX_W = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               doRun,
  output logic               isRunning,
  output logic               wasSuccessful,
  output logic               opStart,
  output logic [IDX_W-1:0]   opIndex,
  input  logic               opDone,
  input  logic               opPass,
  output logic [CYCLE_W-1:0] cycleCount,
  output logic [IDX_W-1:0]   failIndex,
  output logic               timedOut
);

  localparam int unsigned WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_OPS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic                 is_running_q, is_running_d;
  logic                 was_successful_q, was_successful_d;
  logic                 op_start_q, op_start_d;
  logic [IDX_W-1:0]     op_index_q, op_index_d;
  logic [CYCLE_W-1:0]   cycle_count_q, cycle_count_d;
  logic [IDX_W-1:0]     fail_index_q, fail_index_d;
  logic                 timed_out_q, timed_out_d;
  logic [WAIT_W-1:0]    wait_cnt_q, wait_cnt_d;

  always_comb begin
    state_d          = state_q;
    was_successful_d = was_successful_q;
    op_index_d       = op_index_q;
    cycle_count_d    = cycle_count_q;
    fail_index_d     = fail_index_q;
    timed_out_d      = timed_out_q;
    wait_cnt_d       = wait_cnt_q;

    // Saturating run-length counter; the start transition below overrides it.
    if ((state_q == S_ISSUE || state_q == S_WAIT) && cycle_count_q != '1) begin
      cycle_count_d = cycle_count_q + 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (doRun) begin
          state_d          = S_ISSUE;
          op_index_d       = '0;
          cycle_count_d    = '0;
          was_successful_d = 1'b0;
          timed_out_d      = 1'b0;
          fail_index_d     = '0;
        end
      end
      S_ISSUE: begin
        wait_cnt_d = '0;
        if (!doRun) begin
          state_d          = S_IDLE;
          was_successful_d = 1'b0;
          timed_out_d      = 1'b0;
          fail_index_d     = op_index_q;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        wait_cnt_d = wait_cnt_q + 1'b1;
        // Abort outranks completion, and completion outranks timeout.
        if (!doRun) begin
          state_d          = S_IDLE;
          was_successful_d = 1'b0;
          timed_out_d      = 1'b0;
          fail_index_d     = op_index_q;
        end else if (opDone) begin
          if (!opPass) begin
            state_d          = S_DONE;
            was_successful_d = 1'b0;
            fail_index_d     = op_index_q;
          end else if (op_index_q == LAST_IDX) begin
            state_d          = S_DONE;
            was_successful_d = 1'b1;
          end else begin
            state_d    = S_ISSUE;
            op_index_d = op_index_q + 1'b1;
          end
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d          = S_DONE;
          was_successful_d = 1'b0;
          timed_out_d      = 1'b1;
          fail_index_d     = op_index_q;
        end
      end
      S_DONE: begin
        if (!doRun) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // ISSUE always lasts exactly one cycle, so the pulse is just "entering ISSUE".
    op_start_d   = (state_d == S_ISSUE);
    is_running_d = (state_d == S_ISSUE) || (state_d == S_WAIT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= S_IDLE;
      is_running_q     <= 1'b0;
      was_successful_q <= 1'b0;
      op_start_q       <= 1'b0;
      op_index_q       <= '0;
      cycle_count_q    <= '0;
      fail_index_q     <= '0;
      timed_out_q      <= 1'b0;
      wait_cnt_q       <= '0;
    end else begin
      state_q          <= state_d;
      is_running_q     <= is_running_d;
      was_successful_q <= was_successful_d;
      op_start_q       <= op_start_d;
      op_index_q       <= op_index_d;
      cycle_count_q    <= cycle_count_d;
      fail_index_q     <= fail_index_d;
      timed_out_q      <= timed_out_d;
      wait_cnt_q       <= wait_cnt_d;
    end
  end

  assign isRunning     = is_running_q;
  assign wasSuccessful = was_successful_q;
  assign opStart       = op_start_q;
  assign opIndex       = op_index_q;
  assign cycleCount    = cycle_count_q;
  assign failIndex     = fail_index_q;
  assign timedOut      = timed_out_q;

endmodule

// File: tb/tb_esfa_run_controller.sv
// Scoreboard bench for esfa_run_controller: stimulus queues expected opStart
// indices and run results; a negedge monitor pops and compares them.
module tb_esfa_run_controller;

  localparam int NUM_OPS = 16;
  localparam int TIMEOUT = 8;
  localparam int CYCLE_W = 6;
  localparam int IDX_W   = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic               doRun;
  logic               isRunning;
  logic               wasSuccessful;
  logic               opStart;
  logic [IDX_W-1:0]   opIndex;
  logic               opDone;
  logic               opPass;
  logic [CYCLE_W-1:0] cycleCount;
  logic [IDX_W-1:0]   failIndex;
  logic               timedOut;

  always #5 clk = ~clk;

  esfa_run_controller #(
    .NUM_OPS(NUM_OPS),
    .TIMEOUT(TIMEOUT),
    .CYCLE_W(CYCLE_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .doRun        (doRun),
    .isRunning    (isRunning),
    .wasSuccessful(wasSuccessful),
    .opStart      (opStart),
    .opIndex      (opIndex),
    .opDone       (opDone),
    .opPass       (opPass),
    .cycleCount   (cycleCount),
    .failIndex    (failIndex),
    .timedOut     (timedOut)
  );

  typedef struct {
    int succ;
    int fidx;
    int tout;
    int cc;
    int gap;
  } res_t;

  int   checks = 0;
  int   errors = 0;
  int   exp_idx_q[$];
  res_t exp_res_q[$];
  int   res_seen = 0;
  int   res_pushed = 0;
  int   cyc = 0;
  int   last_start = 0;
  logic prev_run = 1'b0;
  int   resp_delay[NUM_OPS];   // 0 = worker never answers
  bit   resp_pass[NUM_OPS];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_run(input int nops, input int succ, input int fidx,
                          input int tout, input int cc, input int gap);
    res_t r;
    for (int i = 0; i < nops; i++) exp_idx_q.push_back(i);
    r.succ = succ; r.fidx = fidx; r.tout = tout; r.cc = cc; r.gap = gap;
    exp_res_q.push_back(r);
    res_pushed++;
  endtask

  task automatic wait_res(input int budget);
    int k;
    k = 0;
    while (res_seen < res_pushed && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("run_complete", res_seen, res_pushed);
  endtask

  task automatic wait_op(input int idx, input int budget);
    int found;
    found = 0;
    for (int k = 0; k < budget && found == 0; k++) begin
      @(negedge clk);
      if (opStart === 1'b1 && int'(opIndex) == idx) found = 1;
    end
    chk("wait_opStart", found, 1);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin : monitor
    int   e;
    res_t r;
    cyc = cyc + 1;
    if (opStart === 1'b1) begin
      chk("opStart_expected", int'(exp_idx_q.size() > 0), 1);
      if (exp_idx_q.size() > 0) begin
        e = exp_idx_q.pop_front();
        chk("opIndex", int'(opIndex), e);
        chk("isRunning_at_start", int'(isRunning), 1);
        if (e == 0) begin
          chk("start_cycleCount", int'(cycleCount), 0);
          chk("start_wasSuccessful", int'(wasSuccessful), 0);
          chk("start_timedOut", int'(timedOut), 0);
          chk("start_failIndex", int'(failIndex), 0);
        end
      end
      last_start = cyc;
    end
    if (prev_run === 1'b1 && isRunning === 1'b0) begin
      chk("result_expected", int'(exp_res_q.size() > 0), 1);
      if (exp_res_q.size() > 0) begin
        r = exp_res_q.pop_front();
        chk("wasSuccessful", int'(wasSuccessful), r.succ);
        chk("failIndex", int'(failIndex), r.fidx);
        chk("timedOut", int'(timedOut), r.tout);
        chk("cycleCount", int'(cycleCount), r.cc);
        chk("opStart_at_end", int'(opStart), 0);
        if (r.gap >= 0) chk("end_latency", cyc - last_start, r.gap);
      end
      res_seen++;
    end
    prev_run = isRunning;
  end

  // Worker model: answers resp_delay cycles after opStart
  initial begin : worker
    int idx;
    int d;
    opDone = 1'b0;
    opPass = 1'b0;
    forever begin
      @(negedge clk);
      if (opStart === 1'b1 && reset === 1'b0) begin
        idx = int'(opIndex);
        d   = resp_delay[idx];
        if (d > 0) begin
          repeat (d) @(posedge clk);
          #1;
          opDone = 1'b1;
          opPass = resp_pass[idx];
          @(posedge clk);
          #1;
          opDone = 1'b0;
          opPass = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stimulus
    reset = 1'b1;
    doRun = 1'b0;
    for (int i = 0; i < NUM_OPS; i++) begin
      resp_delay[i] = 1;
      resp_pass[i]  = 1'b1;
    end
    tick(3);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_isRunning", int'(isRunning), 0);
    chk("rst_wasSuccessful", int'(wasSuccessful), 0);
    chk("rst_opStart", int'(opStart), 0);
    chk("rst_opIndex", int'(opIndex), 0);
    chk("rst_cycleCount", int'(cycleCount), 0);
    chk("rst_failIndex", int'(failIndex), 0);
    chk("rst_timedOut", int'(timedOut), 0);

    // Basic pass, minimum-latency worker: 2 cycles per op
    tick(1);
    push_run(16, 1, 0, 0, 32, 2);
    doRun = 1'b1;
    wait_res(200);

    // doRun held high in DONE: no new run, results hold
    tick(100);
    @(negedge clk);
    chk("hold_wasSuccessful", int'(wasSuccessful), 1);
    chk("hold_cycleCount", int'(cycleCount), 32);
    chk("hold_isRunning", int'(isRunning), 0);

    // Re-arm with a single low cycle; op 5 fails
    resp_pass[5] = 1'b0;
    tick(1);
    doRun = 1'b0;
    tick(1);
    push_run(6, 0, 5, 0, 12, 2);
    doRun = 1'b1;
    wait_res(200);
    resp_pass[5] = 1'b1;

    // Op 2 never answered: timeout 9 cycles after its opStart
    tick(1);
    doRun = 1'b0;
    tick(2);
    resp_delay[2] = 0;
    push_run(3, 0, 2, 1, 13, 9);
    doRun = 1'b1;
    wait_res(200);
    resp_delay[2] = 1;

    // opDone on the timeout cycle wins; 16 x 9 cycles saturates a 6-bit count
    tick(1);
    doRun = 1'b0;
    tick(2);
    for (int i = 0; i < NUM_OPS; i++) resp_delay[i] = 8;
    push_run(16, 1, 0, 0, 63, 9);
    doRun = 1'b1;
    wait_res(400);
    for (int i = 0; i < NUM_OPS; i++) resp_delay[i] = 1;

    // Abort during WAIT of op 3, coincident with opDone
    tick(1);
    doRun = 1'b0;
    tick(2);
    push_run(4, 0, 3, 0, 8, 2);
    doRun = 1'b1;
    wait_op(3, 40);
    tick(1);
    doRun = 1'b0;
    wait_res(20);
    tick(5);
    @(negedge clk);
    chk("abort_isRunning", int'(isRunning), 0);
    chk("abort_failIndex", int'(failIndex), 3);

    // Reset during op 7
    tick(1);
    resp_delay[7] = 3;
    push_run(8, 0, 0, 0, 0, -1);
    doRun = 1'b1;
    wait_op(7, 60);
    tick(1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    doRun = 1'b0;
    @(negedge clk);
    chk("mrst_isRunning", int'(isRunning), 0);
    chk("mrst_opStart", int'(opStart), 0);
    chk("mrst_opIndex", int'(opIndex), 0);
    chk("mrst_cycleCount", int'(cycleCount), 0);
    chk("mrst_failIndex", int'(failIndex), 0);
    chk("mrst_wasSuccessful", int'(wasSuccessful), 0);
    chk("mrst_timedOut", int'(timedOut), 0);
    wait_res(5);
    tick(6);
    resp_delay[7] = 1;

    // Fresh run after reset
    push_run(16, 1, 0, 0, 32, 2);
    doRun = 1'b1;
    wait_res(200);
    tick(2);
    doRun = 1'b0;
    tick(3);

    chk("pending_opStart_expectations", exp_idx_q.size(), 0);
    chk("pending_result_expectations", exp_res_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
